// File: rtl/pwm_multi.sv
// Multi-channel PWM with a shared period counter and double-buffered period/duty registers.
// Optional up/down counting is enabled with the PWM_CENTER_ALIGN_EN macro, which adds a center_mode input.
module pwm_multi #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     cfg_we,
  input  logic [WIDTH-1:0]         period_in,
  input  logic [NUM_CH*WIDTH-1:0]  duty_in,
`ifdef PWM_CENTER_ALIGN_EN
  input  logic                     center_mode,
`endif
  output logic [NUM_CH-1:0]        pwm_out,
  output logic                     cycle_tick,
  output logic                     upd_pending
);

  logic [WIDTH-1:0]        counter_r;
  logic [WIDTH-1:0]        counter_nxt_s;
  logic [WIDTH-1:0]        act_period_r;
  logic [WIDTH-1:0]        shd_period_r;
  logic [WIDTH-1:0]        period_m1_s;
  logic [NUM_CH*WIDTH-1:0] act_duty_r;
  logic [NUM_CH*WIDTH-1:0] shd_duty_r;
  logic [NUM_CH-1:0]       cmp_s;
  logic [NUM_CH-1:0]       pwm_out_r;
  logic                    cycle_tick_r;
  logic                    upd_pending_r;
  logic                    wrap_s;
  logic                    boundary_s;
  logic                    xfer_s;

  // Modulo subtraction makes period 0 wrap at all-ones, i.e. a full 2^WIDTH cycle.
  assign period_m1_s = act_period_r - WIDTH'(1'b1);
  assign wrap_s      = (counter_r == period_m1_s);
  assign xfer_s      = (!en) || boundary_s;

  // Per-channel duty compare against the current counter value.
  always_comb begin
    cmp_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cmp_s[i] = (counter_r < act_duty_r[i*WIDTH +: WIDTH]);
    end
  end

`ifdef PWM_CENTER_ALIGN_EN
  logic dir_r;
  logic dir_nxt_s;
  logic act_center_r;
  logic shd_center_r;
  logic p_is_one_s;

  assign p_is_one_s = (act_period_r == WIDTH'(1'b1));

  // Counter sequencing: dir_r=1 means counting down; the period boundary is the down-count reaching 0.
  always_comb begin
    counter_nxt_s = '0;
    dir_nxt_s     = 1'b0;
    boundary_s    = 1'b0;
    if (!en) begin
      counter_nxt_s = '0;
      dir_nxt_s     = 1'b0;
      boundary_s    = 1'b0;
    end else if (act_center_r) begin
      if (p_is_one_s) begin
        counter_nxt_s = '0;
        dir_nxt_s     = 1'b0;
        boundary_s    = 1'b1;
      end else if (dir_r) begin
        if (counter_r == '0) begin
          counter_nxt_s = counter_r + WIDTH'(1'b1);
          dir_nxt_s     = 1'b0;
          boundary_s    = 1'b1;
        end else begin
          counter_nxt_s = counter_r - WIDTH'(1'b1);
          dir_nxt_s     = 1'b1;
        end
      end else if (wrap_s) begin
        counter_nxt_s = counter_r - WIDTH'(1'b1);
        dir_nxt_s     = 1'b1;
      end else begin
        counter_nxt_s = counter_r + WIDTH'(1'b1);
        dir_nxt_s     = 1'b0;
      end
    end else if (wrap_s) begin
      counter_nxt_s = '0;
      boundary_s    = 1'b1;
    end else begin
      counter_nxt_s = counter_r + WIDTH'(1'b1);
    end
  end

  // Direction bit and shadowed mode select; mode applies together with period/duty.
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_r        <= 1'b0;
      act_center_r <= 1'b0;
      shd_center_r <= 1'b0;
    end else begin
      dir_r <= dir_nxt_s;
      if (xfer_s && upd_pending_r) begin
        act_center_r <= shd_center_r;
      end
      if (cfg_we) begin
        shd_center_r <= center_mode;
      end
    end
  end
`else
  // Edge-aligned counter sequencing.
  always_comb begin
    counter_nxt_s = '0;
    boundary_s    = 1'b0;
    if (!en) begin
      counter_nxt_s = '0;
      boundary_s    = 1'b0;
    end else if (wrap_s) begin
      counter_nxt_s = '0;
      boundary_s    = 1'b1;
    end else begin
      counter_nxt_s = counter_r + WIDTH'(1'b1);
      boundary_s    = 1'b0;
    end
  end
`endif

  // Counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter_r    <= '0;
      pwm_out_r    <= '0;
      cycle_tick_r <= 1'b0;
    end else begin
      counter_r    <= counter_nxt_s;
      pwm_out_r    <= {NUM_CH{en}} & cmp_s;
      cycle_tick_r <= boundary_s;
    end
  end

  // Shadow capture and shadow-to-active transfer; a write coincident with a transfer stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_period_r  <= '0;
      shd_period_r  <= '0;
      act_duty_r    <= '0;
      shd_duty_r    <= '0;
      upd_pending_r <= 1'b0;
    end else begin
      if (xfer_s && upd_pending_r) begin
        act_period_r <= shd_period_r;
        act_duty_r   <= shd_duty_r;
      end
      if (cfg_we) begin
        shd_period_r  <= period_in;
        shd_duty_r    <= duty_in;
        upd_pending_r <= 1'b1;
      end else if (xfer_s) begin
        upd_pending_r <= 1'b0;
      end else begin
        upd_pending_r <= upd_pending_r;
      end
    end
  end

  assign pwm_out     = pwm_out_r;
  assign cycle_tick  = cycle_tick_r;
  assign upd_pending = upd_pending_r;

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: a 4-channel 16-bit instance and a 1-channel 4-bit instance checked against a cycle-phase model.
module tb_pwm_multi;
  localparam int NCH = 4;
  localparam int W   = 16;
  localparam int WB  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, en, cfg_we;
  logic [W-1:0]     period_in;
  logic [NCH*W-1:0] duty_in;
  logic [NCH-1:0]   pwm_out;
  logic             cycle_tick, upd_pending;

  logic             b_rst, b_en, b_we;
  logic [WB-1:0]    b_period, b_duty;
  logic [0:0]       b_pwm;
  logic             b_tick, b_pend;
`ifdef PWM_CENTER_ALIGN_EN
  logic center_mode = 1'b0;
  logic b_center    = 1'b0;
`endif

  pwm_multi #(.NUM_CH(NCH), .WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .period_in(period_in), .duty_in(duty_in),
`ifdef PWM_CENTER_ALIGN_EN
    .center_mode(center_mode),
`endif
    .pwm_out(pwm_out), .cycle_tick(cycle_tick), .upd_pending(upd_pending));

  pwm_multi #(.NUM_CH(1), .WIDTH(WB)) u_dut_b (
    .clk(clk), .rst(b_rst), .en(b_en), .cfg_we(b_we), .period_in(b_period), .duty_in(b_duty),
`ifdef PWM_CENTER_ALIGN_EN
    .center_mode(b_center),
`endif
    .pwm_out(b_pwm), .cycle_tick(b_tick), .upd_pending(b_pend));

  int checks = 0;
  int errors = 0;

  // Reference model state: phase within the period, active/shadow settings, expected outputs.
  int m_cnt[2];
  int m_aper[2];
  int m_sper[2];
  int m_aduty[2][4];
  int m_sduty[2][4];
  bit m_pend[2];
  bit m_pwm[2][4];
  bit m_tick[2];

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int d);
    logic r, e, we;
    int   pin, w, nch, peff;
    int   din[4];
    bit   wrap;
    if (d == 0) begin
      r = rst; e = en; we = cfg_we; pin = int'(period_in); w = W; nch = NCH;
      for (int i = 0; i < 4; i++) din[i] = int'(duty_in[i*W +: W]);
    end else begin
      r = b_rst; e = b_en; we = b_we; pin = int'(b_period); w = WB; nch = 1;
      for (int i = 0; i < 4; i++) din[i] = 0;
      din[0] = int'(b_duty);
    end
    if (r) begin
      m_cnt[d] = 0; m_aper[d] = 0; m_sper[d] = 0; m_pend[d] = 1'b0; m_tick[d] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_aduty[d][i] = 0; m_sduty[d][i] = 0; m_pwm[d][i] = 1'b0;
      end
    end else begin
      peff = (m_aper[d] == 0) ? (1 << w) : m_aper[d];
      wrap = (m_cnt[d] == peff - 1);
      for (int i = 0; i < nch; i++) m_pwm[d][i] = e && (m_cnt[d] < m_aduty[d][i]);
      m_tick[d] = e && wrap;
      if ((!e || wrap) && m_pend[d]) begin
        m_aper[d] = m_sper[d];
        for (int i = 0; i < 4; i++) m_aduty[d][i] = m_sduty[d][i];
        m_pend[d] = 1'b0;
      end
      if (we) begin
        m_sper[d] = pin;
        for (int i = 0; i < 4; i++) m_sduty[d][i] = din[i];
        m_pend[d] = 1'b1;
      end
      m_cnt[d] = e ? (m_cnt[d] + 1) % peff : 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    for (int i = 0; i < NCH; i++) chk($sformatf("pwm%0d", i), pwm_out[i], m_pwm[0][i]);
    chk("tick", cycle_tick, m_tick[0]);
    chk("pend", upd_pending, m_pend[0]);
    chk("b_pwm", b_pwm[0], m_pwm[1][0]);
    chk("b_tick", b_tick, m_tick[1]);
    chk("b_pend", b_pend, m_pend[1]);
  endtask

  task automatic wait_cnt(input int target);
    for (int k = 0; k < 40 && m_cnt[0] != target; k++) step();
  endtask

  initial begin
    int h[4];
    int ticks, hb, tb_ticks;
    rst = 1'b1; en = 1'b0; cfg_we = 1'b0; period_in = '0; duty_in = '0;
    b_rst = 1'b1; b_en = 1'b0; b_we = 1'b0; b_period = '0; b_duty = '0;
    step(); step();
    rst = 1'b0; b_rst = 1'b0;
    step();

    // Period 10, duties {0,3,10,12}; narrow instance period 0 (16 clocks), duty 5.
    period_in = 16'd10;
    duty_in   = {16'd12, 16'd10, 16'd3, 16'd0};
    cfg_we = 1'b1; b_period = 4'd0; b_duty = 4'd5; b_we = 1'b1;
    step();
    cfg_we = 1'b0; b_we = 1'b0;
    step();
    en = 1'b1; b_en = 1'b1;
    for (int i = 0; i < 4; i++) h[i] = 0;
    ticks = 0; hb = 0; tb_ticks = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (k < 10) begin
        for (int i = 0; i < 4; i++) h[i] += int'(pwm_out[i]);
        ticks += int'(cycle_tick);
      end
      hb += int'(b_pwm[0]);
      tb_ticks += int'(b_tick);
    end
    chk_int("ch0_high", h[0], 0);
    chk_int("ch1_high", h[1], 3);
    chk_int("ch2_high", h[2], 10);
    chk_int("ch3_high", h[3], 10);
    chk_int("ticks_p10", ticks, 1);
    chk_int("b_high_p0", hb, 5);
    chk_int("b_ticks_p0", tb_ticks, 1);

    // Mid-cycle write at counter 4: current cycle keeps 3, next cycle 6.
    wait_cnt(4);
    duty_in = {16'd12, 16'd10, 16'd6, 16'd0};
    cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
    chk("pend_after_mid_write", upd_pending, 1'b1);
    wait_cnt(0);
    h[1] = 0;
    for (int k = 0; k < 10; k++) begin step(); h[1] += int'(pwm_out[1]); end
    chk_int("ch1_high_after_update", h[1], 6);

    // Write 5 mid-cycle, then 8 exactly in the wrap cycle.
    wait_cnt(4);
    duty_in = {16'd12, 16'd10, 16'd5, 16'd0};
    cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
    wait_cnt(9);
    duty_in = {16'd12, 16'd10, 16'd8, 16'd0};
    cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
    h[1] = 0;
    for (int k = 0; k < 10; k++) begin step(); h[1] += int'(pwm_out[1]); end
    chk_int("ch1_high_prev_shadow", h[1], 5);
    h[1] = 0;
    for (int k = 0; k < 10; k++) begin step(); h[1] += int'(pwm_out[1]); end
    chk_int("ch1_high_wrap_write", h[1], 8);

    // Reset mid-cycle while enabled: everything stays low until reconfigured.
    wait_cnt(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    h[0] = 0;
    for (int k = 0; k < 20; k++) begin step(); h[0] += int'(|pwm_out) + int'(upd_pending); end
    chk_int("low_after_reset", h[0], 0);

    // Single-cycle disable restarts the counter at 0.
    period_in = 16'd7;
    duty_in   = {16'd7, 16'd1, 16'd4, 16'd2};
    cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
    for (int k = 0; k < 12; k++) step();
    en = 1'b0;
    step();
    chk("pwm_low_while_disabled", pwm_out[3], 1'b0);
    en = 1'b1;
    for (int k = 0; k < 12; k++) step();

    // Randomized traffic on both instances.
    for (int k = 0; k < 500; k++) begin
      cfg_we = ($urandom_range(0, 11) == 0);
      if (cfg_we) begin
        period_in = W'($urandom_range(1, 20));
        for (int i = 0; i < NCH; i++) duty_in[i*W +: W] = W'($urandom_range(0, 22));
      end
      en  = ($urandom_range(0, 39) != 0);
      rst = ($urandom_range(0, 249) == 0);
      b_we = ($urandom_range(0, 9) == 0);
      if (b_we) begin
        b_period = WB'($urandom_range(0, 15));
        b_duty   = WB'($urandom_range(0, 15));
      end
      b_en  = ($urandom_range(0, 29) != 0);
      b_rst = ($urandom_range(0, 249) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
